// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int XLEN   = 64;

  localparam int             DEPTH_DEFAULT    = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // Instruction fetches are word aligned; the low two PC bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs. Flush beats push/pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when a pop frees the slot.
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;

  // Pointer and occupancy update; flush returns everything to empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Decoupled fetch front end: owns the fetch PC, issues one outstanding
// request at a time and buffers returned words for the decode stage.
module instruction_fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = DEPTH_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = XLEN + INST_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] hold_addr_q, hold_addr_d;
  logic [XLEN-1:0] target_pc;
  logic            push, pop;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count, count_after_ack;
  logic [EW-1:0]   head_data;

  assign target_pc = align_pc(redirect_pc);

  // A redirect suppresses both the pop and the push of its cycle.
  assign pop  = !fifo_empty && inst_ready && !redirect;
  assign push = (state_q == REQ) && imem_ack && !redirect;

  // Occupancy once the word being acked lands, net of a same-cycle pop.
  assign count_after_ack = fifo_count + CW'(1) - CW'(pop);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data ({fetch_pc_q, imem_rdata}),
    .pop       (pop),
    .flush     (redirect),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Request is a decode of the state register, forced low while in reset.
  assign imem_req   = reset && (state_q != IDLE);
  assign imem_addr  = (state_q == DISCARD) ? hold_addr_q : fetch_pc_q;
  assign inst_valid = !fifo_empty;
  assign inst       = inst_valid ? head_data[INST_W-1:0] : '0;
  assign inst_pc    = inst_valid ? head_data[EW-1:INST_W] : '0;

  // Next-state, fetch PC and discard-address logic.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    hold_addr_d = hold_addr_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = target_pc;
          state_d    = REQ;
        end else if (!fifo_full || pop) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_d = target_pc;
          if (!imem_ack) begin
            // Old request still in flight: keep presenting it until acked.
            hold_addr_d = fetch_pc_q;
            state_d     = DISCARD;
          end
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + XLEN'(4);
          state_d    = (count_after_ack < DEPTH_C) ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (redirect) fetch_pc_d = target_pc;
        // FIFO was flushed on entry, so there is always room to restart.
        if (imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset restarts fetching from RESET_PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= REQ;
      fetch_pc_q  <= RESET_PC;
      hold_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      hold_addr_q <= hold_addr_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue with a behavioural memory.
module tb_instruction_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;

  int checks   = 0;
  int failures = 0;

  // Memory model controls.
  int   wait_cycles = 0;
  int   wait_cnt;
  logic ack_mode  = 1'b0;   // 0: automatic after wait_cycles, 1: force_ack
  logic force_ack = 1'b0;

  always #5 clk = ~clk;

  instruction_fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign imem_ack   = ack_mode ? (imem_req && force_ack)
                               : (imem_req && (wait_cnt >= wait_cycles));

  always @(posedge clk or negedge reset) begin
    if (!reset)                    wait_cnt <= 0;
    else if (!imem_req || imem_ack) wait_cnt <= 0;
    else                           wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic ev, input logic [63:0] ep);
    chk({tag, " valid"}, {63'd0, inst_valid}, {63'd0, ev});
    chk({tag, " pc"}, inst_pc, ev ? ep : 64'd0);
    chk({tag, " inst"}, {32'd0, inst}, ev ? {32'd0, mem_word(ep)} : 64'd0);
  endtask

  task automatic reset_dut(input logic ready, input int waits);
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 64'd0;
    inst_ready  = ready;
    ack_mode    = 1'b0;
    force_ack   = 1'b0;
    wait_cycles = waits;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [63:0] rpc;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        exp_valid;
    logic [63:0] exp_pc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rd, input logic [63:0] rpc,
                              input logic er, input logic [63:0] ea,
                              input logic ev, input logic [63:0] ep);
    vec_t v;
    v.ready = r; v.redir = rd; v.rpc = rpc;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
    return v;
  endfunction

  vec_t vecs [16];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Zero-wait memory: stream, backpressure to full, release, redirect 0x103.
    vecs[0]  = mk(1, 0, 0,      1, 64'h0,   0, 0);
    vecs[1]  = mk(1, 0, 0,      1, 64'h4,   1, 64'h0);
    vecs[2]  = mk(1, 0, 0,      1, 64'h8,   1, 64'h4);
    vecs[3]  = mk(0, 0, 0,      1, 64'hC,   1, 64'h8);
    vecs[4]  = mk(0, 0, 0,      1, 64'h10,  1, 64'h8);
    vecs[5]  = mk(0, 0, 0,      1, 64'h14,  1, 64'h8);
    vecs[6]  = mk(0, 0, 0,      0, 64'h18,  1, 64'h8);
    vecs[7]  = mk(1, 0, 0,      0, 64'h18,  1, 64'h8);
    vecs[8]  = mk(1, 0, 0,      1, 64'h18,  1, 64'hC);
    vecs[9]  = mk(1, 0, 0,      1, 64'h1C,  1, 64'h10);
    vecs[10] = mk(1, 0, 0,      1, 64'h20,  1, 64'h14);
    vecs[11] = mk(1, 0, 0,      1, 64'h24,  1, 64'h18);
    vecs[12] = mk(1, 1, 64'h103, 1, 64'h28, 1, 64'h1C);
    vecs[13] = mk(1, 0, 0,      1, 64'h100, 0, 0);
    vecs[14] = mk(1, 0, 0,      1, 64'h104, 1, 64'h100);
    vecs[15] = mk(1, 0, 0,      1, 64'h108, 1, 64'h104);

    // Outputs while reset is held low.
    reset = 1'b0; redirect = 1'b0; redirect_pc = 64'd0; inst_ready = 1'b1;
    @(negedge clk);
    chk("rst req", {63'd0, imem_req}, 64'd0);
    chk("rst addr", imem_addr, 64'd0);
    chk_head("rst", 1'b0, 64'd0);

    // Table-driven stream.
    reset_dut(1'b1, 0);
    for (int i = 0; i < 16; i++) begin
      inst_ready  = vecs[i].ready;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      @(negedge clk);
      $display("vec %0d req=%0b addr=%h valid=%0b pc=%h", i, imem_req, imem_addr, inst_valid, inst_pc);
      chk($sformatf("vec%0d req", i), {63'd0, imem_req}, {63'd0, vecs[i].exp_req});
      chk($sformatf("vec%0d addr", i), imem_addr, vecs[i].exp_addr);
      chk_head($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
      @(posedge clk); #1;
    end
    redirect = 1'b0;

    // Hold inst_ready low 10 cycles: four entries, no request, then gapless drain.
    reset_dut(1'b0, 0);
    repeat (10) @(posedge clk);
    #1 inst_ready = 1'b1;
    @(negedge clk);
    chk("bp req while full", {63'd0, imem_req}, 64'd0);
    chk("bp fetch_pc", imem_addr, 64'h10);
    for (int i = 0; i < 6; i++) begin
      if (i != 0) @(negedge clk);
      $display("drain %0d valid=%0b pc=%h", i, inst_valid, inst_pc);
      chk_head($sformatf("drain%0d", i), 1'b1, 64'(4 * i));
      @(posedge clk); #1;
    end

    // Three wait cycles: address held, one instruction every four cycles.
    reset_dut(1'b1, 3);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      $display("wait3 cycle %0d addr=%h valid=%0b pc=%h", c, imem_addr, inst_valid, inst_pc);
      chk($sformatf("wait3 c%0d req", c), {63'd0, imem_req}, 64'd1);
      chk($sformatf("wait3 c%0d addr", c), imem_addr, 64'(4 * (c / 4)));
      chk_head($sformatf("wait3 c%0d", c), (c >= 4) && (c % 4 == 0), 64'(4 * (c / 4 - 1)));
      @(posedge clk); #1;
    end

    // Redirect to 0x100 while the request to 0x20 waits for a late ack.
    reset_dut(1'b1, 0);
    for (int n = 0; n < 50 && imem_addr !== 64'h20; n++) begin
      @(posedge clk); #1;
    end
    chk("find 0x20", imem_addr, 64'h20);
    ack_mode = 1'b1; force_ack = 1'b0;
    redirect = 1'b1; redirect_pc = 64'h100;
    @(negedge clk);
    chk_head("redir pre", 1'b1, 64'h1C);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    $display("discard wait addr=%h valid=%0b", imem_addr, inst_valid);
    chk("discard1 req", {63'd0, imem_req}, 64'd1);
    chk("discard1 addr", imem_addr, 64'h20);
    chk("discard1 valid", {63'd0, inst_valid}, 64'd0);
    @(posedge clk); #1 force_ack = 1'b1;
    @(negedge clk);
    chk("discard2 addr", imem_addr, 64'h20);
    chk("discard2 valid", {63'd0, inst_valid}, 64'd0);
    @(posedge clk); #1 ack_mode = 1'b0; force_ack = 1'b0;
    @(negedge clk);
    $display("after discard addr=%h valid=%0b", imem_addr, inst_valid);
    chk("retarget req", {63'd0, imem_req}, 64'd1);
    chk("retarget addr", imem_addr, 64'h100);
    chk("retarget valid", {63'd0, inst_valid}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_head("retarget head", 1'b1, 64'h100);

    // Reset asserted mid-request with three entries buffered.
    reset_dut(1'b0, 0);
    repeat (3) @(posedge clk);
    #1 wait_cycles = 5;
    @(negedge clk);
    chk("pre-rst addr", imem_addr, 64'hC);
    chk_head("pre-rst", 1'b1, 64'h0);
    #2 reset = 1'b0;
    #1;
    $display("midreset req=%0b addr=%h valid=%0b", imem_req, imem_addr, inst_valid);
    chk("midrst req", {63'd0, imem_req}, 64'd0);
    chk("midrst addr", imem_addr, 64'd0);
    chk_head("midrst", 1'b0, 64'd0);
    wait_cycles = 0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("restart req", {63'd0, imem_req}, 64'd1);
    chk("restart addr", imem_addr, 64'd0);
    chk("restart valid", {63'd0, inst_valid}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_head("restart head", 1'b1, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Decoupled fetch front end for the five-stage RISC-V pipeline. It owns the fetch PC, issues word requests to a variable-latency instruction memory over a req/ack handshake, and buffers returned instructions with their PCs in a small FIFO. It presents them to the IF/ID register with a valid/ready pair. A taken branch from the EX/MEM branch control redirects it, flushing all buffered and in-flight fetches.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- RESET_PC, 64'h0, first fetch address after reset
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- redirect  in  1  taken branch/jump this cycle (branch control switch_branch)
- redirect_pc  in  64  branch target (EX/MEM PC adder); bits [1:0] ignored, treated as 0
- imem_req  out  1  fetch request
- imem_addr  out  64  fetch word address; stable while imem_req=1 and imem_ack=0
- imem_ack  in  1  data valid this cycle; may be combinational, same cycle as req
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- inst_valid  out  1  FIFO head valid
- inst  out  32  head instruction
- inst_pc  out  64  head PC
- inst_ready  in  1  IF/ID accepts head (IF_ID_Write); 0 = hazard stall

## Operation
- State: fetch_pc (64), FIFO of {pc, inst}, count (0..DEPTH), FSM {IDLE, REQ, DISCARD}.
- IDLE: imem_req=0. Go to REQ when count + pushes-pending < DEPTH, i.e. the FIFO has room for the returning word.
- REQ: imem_req=1, imem_addr=fetch_pc. On ack: push {fetch_pc, imem_rdata} and set fetch_pc += 4, wrapping modulo 2^64. Stay in REQ if room remains after the push, accounting for a same-cycle pop; otherwise go to IDLE.
- Only one request is outstanding at a time. Requests are never withdrawn before ack.
- Pop occurs when inst_valid && inst_ready. Push and pop in the same cycle leave count unchanged. Pop when empty is impossible because inst_valid=0.
- Redirect, in any state:
  - Flush the FIFO: count=0, pointers reset.
  - Load fetch_pc = {redirect_pc[63:2], 2'b00}.
  - Suppress any pop in the same cycle, because redirect wins.
  - If in REQ with no ack this cycle, go to DISCARD: hold req and the old addr until ack, drop the data, then go to REQ at the new fetch_pc.
  - If in REQ and ack arrives the same cycle, drop the data and go directly to REQ.
- Redirect during DISCARD: update fetch_pc again and remain in DISCARD.
- Reset (reset=0), asynchronous:
  - fetch_pc=RESET_PC, FIFO empty, FSM=REQ.
  - Outputs while reset=0: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
  - Reset mid-request abandons the transaction; the memory must tolerate this.

## Timing
- After reset deasserts, imem_req=1 with addr RESET_PC in the first cycle.
- Zero-wait memory (ack same cycle): inst_valid rises the cycle after the capturing edge. Sustained throughput is 1 instruction/cycle with inst_ready=1.
- Fetch latency is N+1 cycles from request to inst_valid for N wait cycles.
- Redirect at edge t: inst_valid=0 in cycle t+1. The first target instruction is valid at the earliest in cycle t+2 with zero-wait memory.
- inst, inst_pc and inst_valid are registered (FIFO head) and do not depend combinationally on inst_ready.
- imem_req is a registered FSM output. imem_addr mirrors fetch_pc, or the held address while in DISCARD.

## Structure
- Shared package fetch_pkg: INST_W=32, XLEN=64, DEPTH default, RESET_PC default, fetch_state_t enum {IDLE, REQ, DISCARD}.
- Sub-module fetch_fifo: synchronous FIFO with parameters DEPTH and width. It provides push/pop/flush, full/empty/count, and supports push+pop in the same cycle. Flush has priority over push and pop.
- The top level holds the FSM, fetch_pc, and the room/issue logic.

## Test plan
- Reset then zero-wait memory with inst_ready=1: imem_addr sequence 0,4,8,…; inst_pc 0,4,8 on consecutive cycles from cycle 2; inst matches memory contents.
- inst_ready=0 for 10 cycles, DEPTH=4: exactly 4 entries buffered, imem_req=0 while full; on release, PCs 0..12 drain in order, then 16 follows with no gap.
- Memory with 3 wait cycles: imem_addr is held stable across wait cycles; inst_valid is asserted once per 4 cycles.
- Redirect to 0x100 while a request to 0x20 is pending (ack 2 cycles later): the 0x20 data is dropped, FIFO is empty, next imem_addr=0x100, first inst_pc=0x100.
- Redirect with redirect_pc=0x103 in the same cycle as pop and ack: no pop counted, acked data dropped, fetch from 0x100.
- Assert reset low mid-request while the FIFO holds 3 entries: outputs drop immediately to reset values; after release, fetch restarts at RESET_PC.
